ring_rr_arbiter: RTL

- Round-robin arbiter that shares one resource between N requesters.
- Priority rotates via a one-hot ring pointer, the same structure as the team's ring counter.
- Grants are held while the requester keeps `req` high, bounded by an optional hold timeout.
- Sits between requesting blocks and a shared datapath resource (bus, display mux, memory port).

---
 rtl/ring_arb_pkg.sv | 30 +++
 rtl/rr_pick_onehot.sv | 27 ++
 rtl/ring_rr_arbiter.sv | 84 ++++++++
 3 files changed

// File: rtl/ring_arb_pkg.sv
// Shared types and one-hot ring helpers for round-robin arbitration.
// Helpers work on a MAXN-wide vector; callers cast to their own width.
package ring_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam int MAXN = 64;

   // One step around an n-entry ring; bit n-1 wraps back to bit 0.
   function automatic logic [MAXN-1:0] rotate_left1(input logic [MAXN-1:0] v, input int n);
      logic [MAXN-1:0] ring_mask;
      ring_mask = (n >= MAXN) ? '1 : ((MAXN'(1) << n) - MAXN'(1));
      return ((v << 1) | (v >> (n - 1))) & ring_mask;
   endfunction

   function automatic int unsigned onehot_to_bin(input logic [MAXN-1:0] v);
      int unsigned b;
      logic [MAXN-1:0] s;
      b = 0;
      for (int i = 0; i < MAXN; i++) begin
         s = v >> i;
         if (s[0]) b = b | i;
      end
      return b;
   endfunction

endpackage

// File: rtl/rr_pick_onehot.sv
// Combinational round-robin pick: first set req bit at or above ptr, wrapping.
// The request vector is doubled so the wrap becomes a plain lowest-bit search.
module rr_pick_onehot #(
   parameter int N = 4
) (
   input  logic [N-1:0] req,
   input  logic [N-1:0] ptr,
   output logic [N-1:0] win,
   output logic         any
);

   localparam int W = 2 * N;

   logic [W-1:0] dbl;
   logic [W-1:0] mask;
   logic [W-1:0] masked;
   logic [W-1:0] iso;

   assign dbl    = {req, req};
   // Lower copy keeps bits at/above ptr; upper copy supplies the wrapped tail.
   assign mask   = ~({{N{1'b0}}, ptr} - W'(1));
   assign masked = dbl & mask;
   assign iso    = masked & (~masked + W'(1));
   assign win    = iso[N-1:0] | iso[W-1:N];
   assign any    = |req;

endmodule

// File: rtl/ring_rr_arbiter.sv
// Round-robin arbiter with a one-hot ring priority pointer, held grants and
// an optional hold timeout that forces rotation.
module ring_rr_arbiter
   import ring_arb_pkg::*;
#(
   parameter int N        = 4,
   parameter int MAX_HOLD = 15
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic [N-1:0]                           req,
   output logic [N-1:0]                           gnt,
   output logic                                   gnt_valid,
   output logic [((N > 1) ? $clog2(N) : 1)-1:0]   gnt_id,
   output logic [N-1:0]                           ptr,
   output logic                                   timeout
);

   localparam int CW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] HOLD_LAST = (MAX_HOLD > 0) ? CW'(MAX_HOLD - 1) : '0;

   state_t        state;
   logic [CW-1:0] hold_cnt;
   logic [N-1:0]  nxt_ptr;
   logic [N-1:0]  pick_ptr;
   logic [N-1:0]  win;
   logic          any;
   logic          holding;
   logic          at_limit;

   assign holding  = |(req & gnt);
   assign at_limit = (MAX_HOLD > 0) && (hold_cnt == HOLD_LAST);
   assign nxt_ptr  = N'(rotate_left1(MAXN'(gnt), N));
   // On a handoff the search starts just past the current holder.
   assign pick_ptr = (state == GRANT) ? nxt_ptr : ptr;

   rr_pick_onehot #(.N(N)) u_pick (
      .req (req),
      .ptr (pick_ptr),
      .win (win),
      .any (any)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         gnt      <= '0;
         gnt_id   <= '0;
         ptr      <= N'(1);
         timeout  <= 1'b0;
         hold_cnt <= '0;
      end else begin
         timeout <= 1'b0;
         case (state)
            IDLE: begin
               if (any) begin
                  gnt      <= win;
                  gnt_id   <= IW'(onehot_to_bin(MAXN'(win)));
                  hold_cnt <= '0;
                  state    <= GRANT;
               end
            end
            GRANT: begin
               if (holding && !at_limit) begin
                  if (hold_cnt != '1) hold_cnt <= hold_cnt + CW'(1);
               end else begin
                  // Release or forced rotation; a timed-out holder may win again.
                  ptr      <= nxt_ptr;
                  gnt      <= win;
                  gnt_id   <= IW'(onehot_to_bin(MAXN'(win)));
                  hold_cnt <= '0;
                  timeout  <= holding;
                  state    <= any ? GRANT : IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign gnt_valid = |gnt;

endmodule
